// File: rtl/fp_add_arbiter_pkg.sv
// Shared constants and types for the FP32 add/sub arbiter slice.
package fp_pkg;

  localparam logic [31:0] FP32_QNAN = 32'h7FFF_FFFF;
  localparam logic        OP_ADD    = 1'b0;
  localparam logic        OP_SUB    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic        op;
    logic [31:0] x;
    logic [31:0] y;
  } fp_req_t;

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Request, response and adder-side handshake bundle of the arbiter.
interface fp_add_arbiter_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_op;
  logic [NREQ-1:0][31:0] req_x;
  logic [NREQ-1:0][31:0] req_y;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_z;
  logic                  resp_err;
  logic                  add_rd;
  logic                  add_op;
  logic [31:0]           add_x;
  logic [31:0]           add_y;
  logic                  add_wr;
  logic [31:0]           add_z;
  logic                  add_rst;
  logic                  busy;

  // master: requesters plus the shared adder; slave: the arbiter itself
  modport master (
    output req_valid, req_op, req_x, req_y, resp_ready, add_wr, add_z,
    input  req_ready, resp_valid, resp_id, resp_z, resp_err,
           add_rd, add_op, add_x, add_y, add_rst, busy
  );
  modport slave (
    input  req_valid, req_op, req_x, req_y, resp_ready, add_wr, add_z,
    output req_ready, resp_valid, resp_id, resp_z, resp_err,
           add_rd, add_op, add_x, add_y, add_rst, busy
  );
endinterface

// File: rtl/fp_add_arbiter_rr.sv
// Combinational round-robin picker: first request at or after ptr+1 wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx
);
  logic found;
  int   j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    grant = '0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = ID_W'(j);
      end
    end
    if (en && found) grant[idx] = 1'b1;
  end
endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one FP32 add/sub unit among NREQ requesters; one op in flight,
// results returned tagged by requester, watchdog aborts a hung adder.
module fp_add_arbiter
  import fp_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              reset,
  fp_add_arbiter_if.slave  bus
);
  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win_idx;
  logic [NREQ-1:0] grant;
  logic [CNT_W-1:0] cnt;
  fp_req_t         cur;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .en    (state == ST_IDLE),
    .grant (grant),
    .idx   (win_idx)
  );

  assign bus.req_ready = grant;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.add_op    = cur.op;
  assign bus.add_x     = cur.x;
  assign bus.add_y     = cur.y;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      cnt            <= '0;
      cur            <= '0;
      bus.add_rd     <= 1'b0;
      bus.add_rst    <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_id    <= '0;
      bus.resp_z     <= '0;
    end else begin
      bus.add_rd  <= 1'b0;
      bus.add_rst <= 1'b0;
      case (state)
        ST_IDLE: if (|grant) begin
          cur         <= '{op: bus.req_op[win_idx], x: bus.req_x[win_idx], y: bus.req_y[win_idx]};
          bus.resp_id <= win_idx;
          ptr         <= win_idx;
          bus.add_rd  <= 1'b1;
          state       <= ST_ISSUE;
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          // a done landing on the timeout cycle still counts as a real result
          if (bus.add_wr) begin
            bus.resp_z     <= bus.add_z;
            bus.resp_err   <= 1'b0;
            bus.resp_valid <= 1'b1;
            state          <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            bus.resp_z     <= FP32_QNAN;
            bus.resp_err   <= 1'b1;
            bus.add_rst    <= 1'b1;
            bus.resp_valid <= 1'b1;
            state          <= ST_RESP;
          end
        end
        ST_RESP: if (bus.resp_ready) begin
          bus.resp_valid <= 1'b0;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Randomized bench for fp_add_arbiter with an FP adder stub and a reference model.
module tb_fp_add_arbiter;
  import fp_pkg::*;

  localparam int NREQ = 4, ID_W = 2, TIMEOUT = 20, ADD_LAT = 8, NOPS = 40;

  logic clk = 1'b0, reset = 1'b1;
  fp_add_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus();
  fp_add_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int id; logic [NREQ-1:0] vld; logic [31:0] x; logic [31:0] y; logic op; } grant_t;
  typedef struct { int cyc; int id; logic [31:0] z; logic err; } resp_t;
  grant_t gq[$];
  resp_t  rq[$];
  int     rdq[$];
  logic   rdop[$];
  int     rstq[$];
  int     ready_bad = 0;
  bit     outstanding = 0;
  int     n_chk = 0, n_err = 0;
  bit     stub_en = 1, rand_lat = 0, stray = 0;
  int     stub_cnt = 0;
  logic [31:0] stub_z = '0;

  // FP32 <-> real for normal numbers and zero; operands are small integers so results are exact
  function automatic real f2r(logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) return 0.0;
    d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction
  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction
  function automatic logic [31:0] fp_model(logic [31:0] x, logic [31:0] y, logic op);
    return r2f(op ? f2r(x) - f2r(y) : f2r(x) + f2r(y));
  endfunction
  function automatic int rr_pick(logic [NREQ-1:0] v, int p);
    for (int k = 1; k <= NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction
  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = r2f(real'($urandom_range(1, 4096)));
    v[31] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // adder stub: done ADD_LAT cycles after the cycle following the start pulse
  initial begin
    bus.add_wr = 1'b0; bus.add_z = '0;
    forever begin
      @(negedge clk);
      bus.add_wr = 1'b0;
      if (stray) begin bus.add_wr = 1'b1; bus.add_z = 32'h1234_5678; stray = 0; end
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin bus.add_wr = 1'b1; bus.add_z = stub_z; end
      end
      if (bus.add_rd && stub_en) begin
        stub_cnt = (rand_lat ? $urandom_range(0, 12) : ADD_LAT) + 1;
        stub_z   = fp_model(bus.add_x, bus.add_y, bus.add_op);
      end
    end
  end

  // event logger; transfers are judged after inputs settle mid-cycle
  initial forever begin
    @(negedge clk); #2;
    if (reset) outstanding = 0;
    else begin
      if ($countones(bus.req_ready) > 1 || (bus.req_ready != '0 && outstanding)) ready_bad++;
      for (int i = 0; i < NREQ; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          gq.push_back('{cyc: cyc, id: i, vld: bus.req_valid, x: bus.req_x[i], y: bus.req_y[i], op: bus.req_op[i]});
          outstanding = 1;
        end
      if (bus.add_rd) begin rdq.push_back(cyc); rdop.push_back(bus.add_op); end
      if (bus.add_rst) rstq.push_back(cyc);
      if (bus.resp_valid && bus.resp_ready) begin
        rq.push_back('{cyc: cyc, id: int'(bus.resp_id), z: bus.resp_z, err: bus.resp_err});
        outstanding = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(); @(negedge clk); endtask
  task automatic clear_logs();
    gq.delete(); rq.delete(); rdq.delete(); rdop.delete(); rstq.delete(); ready_bad = 0;
  endtask
  task automatic drive_idle();
    bus.req_valid = '0; bus.req_op = '0; bus.req_x = '0; bus.req_y = '0; bus.resp_ready = 1'b0;
  endtask
  task automatic apply_reset();
    tick(); reset = 1'b1; drive_idle();
    repeat (2) tick();
    reset = 1'b0;
  endtask
  task automatic wait_grants(input int n, input int budget, input string tag);
    int b = budget;
    while (gq.size() < n && b > 0) begin tick(); b--; end
    if (gq.size() < n) begin
      n_chk++; n_err++;
      $display("FAIL %s_grant_wait: got %0d grants, need %0d", tag, gq.size(), n);
    end
  endtask
  task automatic wait_resps(input int n, input int budget, input string tag);
    int b = budget;
    while (rq.size() < n && b > 0) begin tick(); b--; end
    if (rq.size() < n) begin
      n_chk++; n_err++;
      $display("FAIL %s_resp_wait: got %0d responses, need %0d", tag, rq.size(), n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++; if (bus.req_ready !== '0) begin n_err++; $display("FAIL rst_ready: got %b expected 0", bus.req_ready); end
    n_chk++; if ({bus.resp_valid, bus.resp_err, bus.add_rd, bus.add_rst, bus.add_op, bus.busy} !== 6'b0) begin
      n_err++; $display("FAIL rst_ctrl: got %b expected 000000",
        {bus.resp_valid, bus.resp_err, bus.add_rd, bus.add_rst, bus.add_op, bus.busy}); end
    n_chk++; if (bus.resp_id !== '0) begin n_err++; $display("FAIL rst_id: got %h expected 0", bus.resp_id); end
    n_chk++; if (bus.resp_z !== '0) begin n_err++; $display("FAIL rst_z: got %h expected 0", bus.resp_z); end
    n_chk++; if ({bus.add_x, bus.add_y} !== 64'd0) begin n_err++; $display("FAIL rst_xy: got %h %h expected 0", bus.add_x, bus.add_y); end
  endtask

  task automatic single_op(input int r, input logic [31:0] x, input logic [31:0] y, input logic op,
                           input logic [31:0] exp_z, input string tag);
    int g;
    clear_logs();
    bus.req_x[r] = x; bus.req_y[r] = y; bus.req_op[r] = op; bus.resp_ready = 1'b1;
    bus.req_valid = '0; bus.req_valid[r] = 1'b1;
    wait_grants(1, 20, tag);
    bus.req_valid = '0;
    wait_resps(1, 40, tag);
    g = gq[0].cyc;
    n_chk++; if (gq[0].id != r) begin n_err++; $display("FAIL %s_grant_id: got %0d expected %0d", tag, gq[0].id, r); end
    n_chk++; if (rdq.size() != 1 || rdq[0] != g + 1) begin
      n_err++; $display("FAIL %s_add_rd: got %0d pulses first at %0d expected 1 at %0d", tag, rdq.size(), rdq[0], g + 1); end
    n_chk++; if (rdop[0] !== op) begin n_err++; $display("FAIL %s_add_op: got %b expected %b", tag, rdop[0], op); end
    n_chk++; if (rq[0].id != r || rq[0].z !== exp_z || rq[0].err !== 1'b0) begin
      n_err++; $display("FAIL %s_resp: got id %0d z %h err %b expected id %0d z %h err 0",
        tag, rq[0].id, rq[0].z, rq[0].err, r, exp_z); end
    n_chk++; if (rq[0].cyc != g + ADD_LAT + 3) begin
      n_err++; $display("FAIL %s_latency: got %0d expected %0d", tag, rq[0].cyc - g, ADD_LAT + 3); end
  endtask

  task automatic test_single_add(); single_op(0, 32'h3F80_0000, 32'h4000_0000, OP_ADD, 32'h4040_0000, "add"); endtask
  task automatic test_sub();        single_op(2, 32'h4040_0000, 32'h3F80_0000, OP_SUB, 32'h4000_0000, "sub"); endtask

  task automatic test_round_robin();
    int p = 0, e;
    apply_reset(); clear_logs();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[i] = rand_fp(); bus.req_y[i] = rand_fp(); bus.req_op[i] = 1'($urandom_range(0, 1));
    end
    bus.resp_ready = 1'b1; bus.req_valid = '1;
    wait_grants(5, 200, "rr");
    bus.req_valid = '0;
    wait_resps(5, 60, "rr");
    for (int k = 0; k < 5 && k < gq.size() && k < rq.size(); k++) begin
      e = rr_pick(gq[k].vld, p); p = e;
      n_chk++; if (gq[k].id != e) begin n_err++; $display("FAIL rr_order%0d: got %0d expected %0d", k, gq[k].id, e); end
      n_chk++; if (rq[k].id != e || rq[k].z !== fp_model(gq[k].x, gq[k].y, gq[k].op)) begin
        n_err++; $display("FAIL rr_resp%0d: got id %0d z %h expected id %0d z %h", k, rq[k].id, rq[k].z, e,
          fp_model(gq[k].x, gq[k].y, gq[k].op)); end
    end
    n_chk++; if (ready_bad != 0) begin n_err++; $display("FAIL rr_ready_busy: got %0d bad cycles expected 0", ready_bad); end
  endtask

  task automatic test_backpressure();
    int b = 40, a;
    logic [31:0] ez;
    apply_reset(); clear_logs();
    bus.req_x[1] = rand_fp(); bus.req_y[1] = rand_fp(); bus.req_op[1] = 1'b0;
    bus.req_x[3] = rand_fp(); bus.req_y[3] = rand_fp(); bus.req_op[3] = 1'b1;
    ez = fp_model(bus.req_x[1], bus.req_y[1], 1'b0);
    bus.req_valid = 4'b1010;
    wait_grants(1, 20, "bp");
    bus.req_valid[1] = 1'b0;
    while (!bus.resp_valid && b > 0) begin tick(); b--; end
    for (int i = 0; i < 10; i++) begin
      n_chk++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1 || bus.resp_z !== ez || bus.resp_err !== 1'b0) begin
        n_err++; $display("FAIL bp_hold%0d: got v %b id %0d z %h err %b expected v 1 id 1 z %h err 0",
          i, bus.resp_valid, bus.resp_id, bus.resp_z, bus.resp_err, ez); end
      n_chk++; if (bus.req_ready !== '0) begin n_err++; $display("FAIL bp_ready%0d: got %b expected 0", i, bus.req_ready); end
      tick();
    end
    bus.resp_ready = 1'b1; a = cyc;
    wait_grants(2, 10, "bp");
    n_chk++; if (gq[1].cyc != a + 1 || gq[1].id != 3) begin
      n_err++; $display("FAIL bp_next_grant: got id %0d at +%0d expected id 3 at +1", gq[1].id, gq[1].cyc - a); end
    bus.req_valid = '0;
    wait_resps(2, 40, "bp");
  endtask

  task automatic test_timeout();
    int g;
    clear_logs(); stub_en = 0;
    bus.req_x[0] = rand_fp(); bus.req_y[0] = rand_fp(); bus.resp_ready = 1'b1; bus.req_valid = 4'b0001;
    wait_grants(1, 20, "to");
    bus.req_valid = '0;
    wait_resps(1, TIMEOUT + 20, "to");
    g = gq[0].cyc;
    n_chk++; if (rq[0].cyc != g + TIMEOUT + 2 || rq[0].err !== 1'b1 || rq[0].z !== 32'h7FFF_FFFF) begin
      n_err++; $display("FAIL to_resp: got +%0d err %b z %h expected +%0d err 1 z 7fffffff",
        rq[0].cyc - g, rq[0].err, rq[0].z, TIMEOUT + 2); end
    n_chk++; if (rstq.size() != 1 || rstq[0] != g + TIMEOUT + 2) begin
      n_err++; $display("FAIL to_add_rst: got %0d pulses first at +%0d expected 1 at +%0d",
        rstq.size(), rstq[0] - g, TIMEOUT + 2); end
    stub_en = 1; stray = 1;
    repeat (10) tick();
    n_chk++; if (rq.size() != 1 || bus.resp_valid !== 1'b0) begin
      n_err++; $display("FAIL to_stray: got %0d responses valid %b expected 1 and 0", rq.size(), bus.resp_valid); end
  endtask

  task automatic test_reset_mid();
    int g;
    clear_logs();
    bus.req_x[0] = rand_fp(); bus.req_y[0] = rand_fp(); bus.resp_ready = 1'b1; bus.req_valid = 4'b0001;
    wait_grants(1, 20, "rm");
    bus.req_valid = '0;
    g = gq[0].cyc;
    while (cyc < g + 4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++; if ({bus.resp_valid, bus.resp_err, bus.add_rd, bus.add_rst, bus.busy} !== 5'b0 ||
                 bus.resp_z !== '0 || bus.add_x !== '0) begin
      n_err++; $display("FAIL rm_reset_vals: got v %b e %b rd %b rst %b busy %b z %h x %h expected all 0",
        bus.resp_valid, bus.resp_err, bus.add_rd, bus.add_rst, bus.busy, bus.resp_z, bus.add_x); end
    repeat (15) tick();
    n_chk++; if (rq.size() != 0) begin n_err++; $display("FAIL rm_no_resp: got %0d responses expected 0", rq.size()); end
    bus.req_valid = '1;
    wait_grants(2, 10, "rm");
    bus.req_valid = '0;
    n_chk++; if (gq[1].id != 1) begin n_err++; $display("FAIL rm_next_grant: got %0d expected 1", gq[1].id); end
    wait_resps(1, 40, "rm");
  endtask

  task automatic test_random();
    int b = 4000, p = 0, e, bad = 0;
    apply_reset(); clear_logs(); rand_lat = 1;
    while (gq.size() < NOPS && b > 0) begin
      tick(); b--;
      bus.req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        bus.req_x[i] = rand_fp(); bus.req_y[i] = rand_fp(); bus.req_op[i] = 1'($urandom_range(0, 1));
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
    end
    bus.req_valid = '0; bus.resp_ready = 1'b1;
    wait_resps(gq.size(), 60, "rand");
    rand_lat = 0;
    n_chk++; if (gq.size() < NOPS || rq.size() != gq.size()) begin
      n_err++; $display("FAIL rand_count: got %0d grants %0d responses expected %0d each", gq.size(), rq.size(), NOPS); end
    for (int k = 0; k < gq.size() && k < rq.size(); k++) begin
      e = rr_pick(gq[k].vld, p); p = e;
      if (gq[k].id != e || rq[k].id != e || rq[k].err !== 1'b0 ||
          rq[k].z !== fp_model(gq[k].x, gq[k].y, gq[k].op)) begin
        bad++;
        $display("FAIL rand_op%0d: got grant %0d resp id %0d z %h err %b expected %0d z %h err 0",
          k, gq[k].id, rq[k].id, rq[k].z, rq[k].err, e, fp_model(gq[k].x, gq[k].y, gq[k].op));
      end
    end
    n_chk++; if (bad != 0) begin n_err++; $display("FAIL rand_ops: got %0d bad ops expected 0", bad); end
    n_chk++; if (ready_bad != 0) begin n_err++; $display("FAIL rand_ready_busy: got %0d expected 0", ready_bad); end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single_add();
    test_sub();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
